// File: rtl/apb_slave_mux_ctrl_pkg.sv
// Shared widths and FSM state encoding for the APB slave mux controller.
package apb_slave_mux_ctrl_pkg;

    localparam int unsigned PADDR_WIDTH    = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ABORT  = 3'd3,
        ST_DONE   = 3'd4
    } apb_state_e;

    // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_slave_mux_ctrl_timeout_cnt.sv
// Per-transfer watchdog: counts unanswered ACCESS cycles and flags the last allowed one.
module apb_timeout_cnt
    import apb_slave_mux_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at TIMEOUT; the FSM leaves ACCESS before that can matter.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_slave_mux_ctrl.sv
// APB address decoder and response mux with a per-transfer watchdog that
// converts hung or unmapped accesses into error completions.
module apb_slave_mux_ctrl
    import apb_slave_mux_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_SLV = 4,
    parameter  int unsigned SEL_MSB = 15,
    parameter  int unsigned SEL_LSB = 12,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned SEL_W   = SEL_MSB - SEL_LSB + 1
) (
    input  logic                              hclk,
    input  logic                              hreset_n,
    input  logic                              psel_en,
    input  logic                              penable,
    input  logic [PADDR_WIDTH-1:0]            paddr,
    output logic [NUM_SLV-1:0]                psel,
    input  logic [NUM_SLV-1:0]                pready,
    input  logic [NUM_SLV-1:0]                pslverr,
    input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata,
    output logic                              pready_x,
    output logic                              pslverr_x,
    output logic [APB_DATA_WIDTH-1:0]         prdata_x,
    output logic                              timeout_err,
    output logic [SEL_W-1:0]                  err_slot
);

    apb_state_e              state_q, state_d;
    logic [SEL_W-1:0]        slot, slot_q, slot_d;
    logic [SEL_W-1:0]        err_slot_q, err_slot_d;
    logic                    mapped, mapped_q, resp, expire, cnt_clr, cnt_en;
    logic                    sel_rdy, sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_data;
    logic                    unused_paddr;

    assign slot         = paddr[SEL_MSB:SEL_LSB];
    assign mapped       = 32'(slot) < NUM_SLV;
    assign mapped_q     = 32'(slot_q) < NUM_SLV;
    assign unused_paddr = ^paddr;

    // Decode on the live address so psel rises in the bridge's own setup cycle.
    always_comb begin
        psel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            psel[i] = psel_en && mapped && (32'(slot) == i) &&
                      ((state_q == ST_IDLE) || (state_q == ST_SETUP) || (state_q == ST_ACCESS));
        end
    end

    always_comb begin
        sel_rdy  = 1'b0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(slot_q) == i) begin
                sel_rdy  = pready[i];
                sel_err  = pslverr[i];
                sel_data = prdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        err_slot_d  = err_slot_q;
        resp        = mapped_q ? sel_rdy : 1'b1;
        pready_x    = 1'b0;
        pslverr_x   = 1'b0;
        prdata_x    = '0;
        timeout_err = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (psel_en) begin
                    state_d = ST_SETUP;
                    slot_d  = slot;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_clr = 1'b1;
            end
            ST_ACCESS: begin
                pready_x  = resp;
                pslverr_x = resp & (mapped_q ? sel_err : 1'b1);
                prdata_x  = mapped_q ? sel_data : '0;
                cnt_en    = ~resp;
                // Completion beats the watchdog when both land in the same cycle.
                if (resp) begin
                    state_d = ST_DONE;
                    if (!mapped_q) err_slot_d = slot_q;
                end else if (expire) begin
                    state_d = ST_ABORT;
                end else if (!psel_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                pready_x    = 1'b1;
                pslverr_x   = 1'b1;
                timeout_err = 1'b1;
                err_slot_d  = slot_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (!psel_en) begin
                    state_d = ST_IDLE;
                end else if ((slot != slot_q) || !penable) begin
                    state_d = ST_SETUP;
                    slot_d  = slot;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            err_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            err_slot_q <= err_slot_d;
        end
    end

    assign err_slot = err_slot_q;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk_i    (hclk),
        .rst_ni   (hreset_n),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .expire_o (expire)
    );

endmodule
